uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
Multi-cycle control unit that sequences the microc datapath (PC, instruction memory, register file, ALU, zero flag).
- Runs a FETCH/EXEC state machine with a configurable instruction-memory wait.
- Decodes the 6-bit Opcode and the zero flag into datapath controls: s_inc, s_inm, we, wez, ALUOp, plus ir_we/pc_we.
- Supports free-run and single-step modes, HALT, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
IMEM_LAT, 1, instruction-memory read latency in cycles (>=1); number of FETCH cycles per instruction.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
run  input  1  level; 1 = free-run, 0 = stop after the current instruction.
step  input  1  one-cycle pulse in IDLE; executes exactly one instruction.
Opcode  input  6  opcode field from the instruction register; valid in EXEC.
zero  input  1  registered zero flag from the datapath.
ir_we  output  1  load instruction register.
pc_we  output  1  load PC.
s_inc  output  1  PC mux: 1 = PC+1, 0 = jump target.
s_inm  output  1  write-data mux: 1 = immediate, 0 = ALU result.
we  output  1  register-file write enable.
wez  output  1  zero-flag write enable.
ALUOp  output  3  ALU operation select.
halted  output  1  1 while in HALT.
illegal  output  1  sticky; set by any undefined opcode executed.
retired  output  CNT_W  count of instructions completed in EXEC; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, any state, including mid-FETCH):
  - state=IDLE, wait counter=0, retired=0, illegal=0.
  - All outputs 0, except s_inc=1; ALUOp=000.
- Outputs are combinational from state, Opcode and zero. Outside EXEC, every write enable (ir_we, pc_we, we, wez) is 0; s_inc=1, s_inm=0, ALUOp=000.
- IDLE: if run|step, go to FETCH and load the wait counter with IMEM_LAT-1; else stay. step is ignored outside IDLE.
- FETCH:
  - Counter !=0: decrement it; ir_we=0.
  - Counter ==0: ir_we=1 for that cycle, next state EXEC.
  - A FETCH lasts exactly IMEM_LAT cycles.
- EXEC: one cycle. Decode uses the Opcode and zero values present in this cycle.
  - 000000 NOP: pc_we=1, s_inc=1.
  - 000001 HALT: pc_we=0; next state HALT; still counts as retired.
  - 000010 J: pc_we=1, s_inc=0.
  - 000100 JZ: pc_we=1, s_inc=~zero.
  - 000101 JNZ: pc_we=1, s_inc=zero.
  - 0100xx LI: pc_we=1, s_inc=1, s_inm=1, we=1, wez=0, ALUOp=000.
  - 1aaaxx ALU (ADD/SUB/MOV/...): pc_we=1, s_inc=1, s_inm=0, we=1, wez=1, ALUOp=aaa.
  - Any other opcode: behaves as NOP and sets illegal=1 at the clock edge.
  - retired increments at the edge leaving EXEC.
  - Next state: HALT if opcode is HALT; else FETCH (counter reloaded) if run=1; else IDLE.
- HALT: halted=1 and all enables 0. Stays in HALT regardless of run/step until reset.
- run dropping during FETCH: the current instruction still completes, then the FSM returns to IDLE.
- Cycles per instruction in free-run: IMEM_LAT+1.

Test Plan:
1. Reset, then run=1, IMEM_LAT=1, stream LI(010000), ALU ADD(1aaa=1000 -> 100000) -> ir_we on cycles 1,3; in EXEC: LI gives we=1,s_inm=1,wez=0; ADD gives we=1,wez=1,ALUOp=000; retired=2 after cycle 4.
2. JNZ (000101) with zero=0 -> s_inc=0,pc_we=1; with zero=1 -> s_inc=1. JZ mirrored. J (000010) -> s_inc=0 regardless of zero.
3. run=0, step pulse in IDLE with IMEM_LAT=3 -> FETCH 3 cycles (ir_we only in 3rd), 1 EXEC, back to IDLE; retired +1; no further fetch without another step.
4. Execute 000011 -> illegal=1 and stays 1 across later legal instructions; pc_we=1,s_inc=1,we=0; retired still increments.
5. HALT (000001) -> pc_we=0 in EXEC, halted=1 next cycle; run/step toggling ignored; async reset mid-HALT or mid-FETCH -> IDLE, outputs at reset values, retired=0, illegal=0.
6. CNT_W=4, run 17 NOPs -> retired wraps to 1.

Source files
------------

// File: rtl/uc_multiciclo_if.sv
// Control-unit <-> datapath bundle for the microc multi-cycle machine.
//
// Ports (master = control unit, slave = datapath / environment):
//   run, step        : sequencing requests. run is a level: 1 = free-run,
//                      0 = stop once the current instruction has finished.
//                      step is a one-cycle pulse and is only honoured while
//                      the control unit is idle. There is no valid/ready
//                      pair; an instruction starts on the first cycle the
//                      unit is idle and sees run|step high.
//   Opcode, zero     : instruction opcode and registered zero flag, sampled
//                      during the single execute cycle.
//   ir_we, pc_we     : instruction-register and PC load enables.
//   s_inc, s_inm     : PC mux (1 = PC+1) and write-data mux (1 = immediate).
//   we, wez          : register-file and zero-flag write enables.
//   ALUOp            : ALU operation select.
//   halted, illegal  : status; illegal is sticky until reset.
//   retired          : retired-instruction counter (wraps).
//   dbg_state        : FSM state for observation: 0 IDLE, 1 FETCH, 2 EXEC, 3 HALT.
interface uc_multiciclo_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic [5:0]       Opcode;
    logic             zero;
    logic             ir_we;
    logic             pc_we;
    logic             s_inc;
    logic             s_inm;
    logic             we;
    logic             wez;
    logic [2:0]       ALUOp;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [1:0]       dbg_state;

    modport master (
        input  run, step, Opcode, zero,
        output ir_we, pc_we, s_inc, s_inm, we, wez, ALUOp,
        output halted, illegal, retired, dbg_state
    );

    modport slave (
        output run, step, Opcode, zero,
        input  ir_we, pc_we, s_inc, s_inm, we, wez, ALUOp,
        input  halted, illegal, retired, dbg_state
    );
endinterface

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the microc datapath.
//
// Sequences IDLE -> FETCH (IMEM_LAT cycles) -> EXEC (1 cycle) and decodes
// the opcode plus zero flag into datapath controls during EXEC. Outside EXEC
// every write enable is low except ir_we on the last FETCH cycle.
//
// Ports:
//   clk    : system clock, rising-edge.
//   reset  : asynchronous, active-high.
//   bus    : uc_multiciclo_if.master (run/step/Opcode/zero in; controls,
//            status, retired counter and dbg_state out).
module uc_multiciclo #(
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    uc_multiciclo_if.master  bus
);

    localparam int WAIT_W = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
    // FETCH counts down from IMEM_LAT-1 to 0, so it spans IMEM_LAT cycles.
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(IMEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q;
    logic               illegal_q;

    logic               ir_we, pc_we, s_inc, s_inm, we, wez;
    logic [2:0]         alu_op;
    logic               retire;
    logic               illegal_hit;
    logic               is_halt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
            if (illegal_hit) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        s_inc       = 1'b1;
        s_inm       = 1'b0;
        we          = 1'b0;
        wez         = 1'b0;
        alu_op      = 3'b000;
        retire      = 1'b0;
        illegal_hit = 1'b0;
        is_halt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run || bus.step) begin
                    state_d = S_FETCH;
                    wait_d  = WAIT_INIT;
                end
            end

            S_FETCH: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    // Memory data is ready on the last FETCH cycle.
                    ir_we   = 1'b1;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                case (bus.Opcode) inside
                    6'b000000: begin
                        // NOP: PC+1 only.
                    end
                    6'b000001: begin
                        pc_we   = 1'b0;
                        is_halt = 1'b1;
                    end
                    6'b000010: s_inc = 1'b0;
                    6'b000100: s_inc = ~bus.zero;
                    6'b000101: s_inc = bus.zero;
                    6'b0100??: begin
                        s_inm = 1'b1;
                        we    = 1'b1;
                    end
                    6'b1?????: begin
                        we     = 1'b1;
                        wez    = 1'b1;
                        alu_op = bus.Opcode[4:2];
                    end
                    default: begin
                        // Undefined opcodes advance the PC like a NOP.
                        illegal_hit = 1'b1;
                    end
                endcase

                if (is_halt) begin
                    state_d = S_HALT;
                end else if (bus.run) begin
                    state_d = S_FETCH;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                // Only reset leaves HALT.
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ir_we     = ir_we;
    assign bus.pc_we     = pc_we;
    assign bus.s_inc     = s_inc;
    assign bus.s_inm     = s_inm;
    assign bus.we        = we;
    assign bus.wez       = wez;
    assign bus.ALUOp     = alu_op;
    assign bus.halted    = (state_q == S_HALT);
    assign bus.illegal   = illegal_q;
    assign bus.retired   = retired_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: a randomized scoreboard on a 3-cycle-fetch,
// 4-bit-counter instance plus a short directed sequence on a 1-cycle-fetch
// instance.
module tb_uc_multiciclo;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;
    localparam int A_LAT = 3;
    localparam int A_CW  = 4;
    localparam int W     = 13;
    // {pc_we, s_inc, s_inm, we, wez, ALUOp} when nothing is being executed
    localparam logic [7:0] CTRL_IDLE = 8'b0100_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uc_multiciclo_if #(.CNT_W(A_CW)) a_if ();
    uc_multiciclo_if #(.CNT_W(16))   b_if ();

    uc_multiciclo #(.IMEM_LAT(A_LAT), .CNT_W(A_CW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    uc_multiciclo #(.IMEM_LAT(1), .CNT_W(16)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    logic [7:0] a_ctrl;
    logic [8:0] b_ctrl9;
    assign a_ctrl  = {a_if.pc_we, a_if.s_inc, a_if.s_inm, a_if.we, a_if.wez, a_if.ALUOp};
    assign b_ctrl9 = {b_if.ir_we, b_if.pc_we, b_if.s_inc, b_if.s_inm, b_if.we, b_if.wez, b_if.ALUOp};

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];   // {illegal_after, retired_after[3:0], ctrl[7:0]}
    logic [A_CW-1:0] m_ret;
    logic            m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the instruction set says each opcode does.
    task automatic predict(input logic [5:0] op, input logic z);
        logic       pc_we, s_inc, s_inm, we, wez, bad;
        logic [2:0] alu;
        int v;
        v = int'(op);
        pc_we = 1'b1; s_inc = 1'b1; s_inm = 1'b0; we = 1'b0; wez = 1'b0;
        alu = 3'd0; bad = 1'b0;
        if (v == 0) begin
        end else if (v == 1) pc_we = 1'b0;
        else if (v == 2) s_inc = 1'b0;
        else if (v == 4) s_inc = !z;
        else if (v == 5) s_inc = z;
        else if (v >= 16 && v <= 19) begin s_inm = 1'b1; we = 1'b1; end
        else if (v >= 32) begin we = 1'b1; wez = 1'b1; alu = 3'((v / 4) % 8); end
        else bad = 1'b1;
        m_ret = m_ret + 1'b1;
        m_ill = m_ill | bad;
        exp_q.push_back({m_ill, m_ret, pc_we, s_inc, s_inm, we, wez, alu});
    endtask

    // ---------------- monitor ----------------
    int           f_len, f_irwe;
    logic         f_last;
    logic         pend;
    logic [W-1:0] pend_w, mon_e;

    always @(negedge clk) begin
        if (reset) begin
            f_len = 0; f_irwe = 0; f_last = 1'b0; pend = 1'b0;
        end else begin
            if (pend) begin
                chk("retired", 32'(a_if.retired), 32'(pend_w[11:8]));
                chk("illegal", 32'(a_if.illegal), 32'(pend_w[12]));
                pend = 1'b0;
            end
            case (a_if.dbg_state)
                ST_EXEC: begin
                    chk("fetch_len", 32'(f_len), 32'(A_LAT));
                    chk("fetch_irwe", 32'(f_irwe * 2 + int'(f_last)), 32'd3);
                    f_len = 0; f_irwe = 0; f_last = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL exec_unexpected: EXEC with opcode 0x%0h, no prediction queued", a_if.Opcode);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("exec_ctrl", 32'({a_if.ir_we, a_ctrl}), 32'({1'b0, mon_e[7:0]}));
                        pend   = 1'b1;
                        pend_w = mon_e;
                    end
                end
                ST_FETCH: begin
                    f_len++;
                    f_irwe += int'(a_if.ir_we);
                    f_last = a_if.ir_we;
                    chk("fetch_ctrl", 32'(a_ctrl), 32'(CTRL_IDLE));
                end
                default: chk("idle_ctrl", 32'({a_if.ir_we, a_ctrl}), 32'({1'b0, CTRL_IDLE}));
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_exec(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (a_if.dbg_state !== ST_EXEC && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (a_if.dbg_state !== ST_EXEC) begin
            n_checks++;
            $display("FAIL %s: no EXEC within 20 cycles, state 0x%0h", tag, a_if.dbg_state);
        end
    endtask

    task automatic issue_op(input bit nop_only, input bit force_bad);
        logic [5:0] op;
        logic       z;
        case ($urandom_range(0, 7))
            0: op = 6'd0;
            1: op = 6'd2;
            2: op = 6'd4;
            3: op = 6'd5;
            4: op = 6'(16 + $urandom_range(0, 3));
            5, 6: op = 6'(32 + $urandom_range(0, 31));
            default: op = 6'($urandom_range(0, 63));
        endcase
        if (op == 6'd1) op = 6'd0;
        if (nop_only) op = 6'd0;
        if (force_bad) op = 6'd3;
        z = 1'($urandom_range(0, 1));
        a_if.Opcode = op;
        a_if.zero   = z;
        predict(op, z);
    endtask

    task automatic burst(input int n, input bit free_run, input bit nop_only, input bit force_bad);
        issue_op(nop_only, force_bad);
        if (free_run) a_if.run = 1'b1;
        else a_if.step = 1'b1;
        @(posedge clk); #1;
        a_if.step = 1'b0;
        // A step pulse while fetching must be ignored.
        if (!free_run && $urandom_range(0, 1) == 1) begin
            a_if.step = 1'b1;
            @(posedge clk); #1;
            a_if.step = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) a_if.run = 1'b0;   // drop run during the last FETCH
            wait_exec("exec_timeout");
            @(posedge clk); #1;
            if (i != n - 1) issue_op(nop_only, 1'b0);
        end
        chk("back_idle", 32'(a_if.dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        chk("stays_idle", 32'(a_if.dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctrl"}, 32'({a_if.ir_we, a_ctrl}), 32'({1'b0, CTRL_IDLE}));
        chk({tag, "_status"}, 32'({a_if.halted, a_if.illegal, a_if.retired}), 32'd0);
        chk({tag, "_state"}, 32'(a_if.dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic z;
        reset = 1'b1;
        a_if.run = 1'b0; a_if.step = 1'b0; a_if.Opcode = 6'd0; a_if.zero = 1'b0;
        b_if.run = 1'b0; b_if.step = 1'b0; b_if.Opcode = 6'd0; b_if.zero = 1'b0;
        m_ret = '0;
        m_ill = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst_a");
        chk("rst_b_ctrl", 32'(b_ctrl9), 32'({1'b0, CTRL_IDLE}));
        chk("rst_b_status", 32'({b_if.halted, b_if.illegal, b_if.retired}), 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-cycle fetch: LI then ADD, ir_we on cycles 1 and 3.
        b_if.Opcode = 6'b010000; b_if.zero = 1'b0; b_if.run = 1'b1;
        @(negedge clk); chk("b_idle_c0", 32'(b_if.ir_we), 32'd0);
        @(negedge clk); chk("b_fetch1_irwe", 32'(b_if.ir_we), 32'd1);
        @(negedge clk); chk("b_li_exec", 32'(b_ctrl9), 32'(9'b0_1_1_1_1_0_000));
        @(posedge clk); #1;
        b_if.Opcode = 6'b100000; b_if.run = 1'b0;
        @(negedge clk); chk("b_fetch2_irwe", 32'(b_if.ir_we), 32'd1);
        @(negedge clk); chk("b_add_exec", 32'(b_ctrl9), 32'(9'b0_1_1_0_1_1_000));
        @(negedge clk); chk("b_retired", 32'({b_if.dbg_state, b_if.retired}), 32'({ST_IDLE, 16'd2}));
        @(posedge clk); #1;

        // Randomized free-run bursts and single steps.
        for (int b = 0; b < 14; b++) begin
            bit fr;
            fr = (b == 0) ? 1'b1 : (b == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (fr) burst($urandom_range(2, 6), 1'b1, 1'b0, b == 0);
            else burst(1, 1'b0, 1'b0, b == 1);
        end

        // HALT, then run/step activity must not move it.
        z = 1'($urandom_range(0, 1));
        a_if.Opcode = 6'd1; a_if.zero = z;
        predict(6'd1, z);
        a_if.step = 1'b1;
        @(posedge clk); #1;
        a_if.step = 1'b0;
        wait_exec("halt_exec");
        @(negedge clk);
        chk("halted_set", 32'(a_if.halted), 32'd1);
        for (int i = 0; i < 4; i++) begin
            a_if.run  = 1'($urandom_range(0, 1));
            a_if.step = ~a_if.step;
            @(negedge clk);
            chk("halt_hold", 32'({a_if.halted, a_if.dbg_state, a_if.retired}), 32'({1'b1, ST_HALT, m_ret}));
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("illegal_before_reset", 32'(a_if.illegal), 32'd1);

        // Asynchronous reset in the middle of HALT.
        @(posedge clk); #2;
        reset = 1'b1;
        a_if.run = 1'b0; a_if.step = 1'b0;
        #1;
        check_reset_vals("async_rst_halt");
        m_ret = '0; m_ill = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;

        // Asynchronous reset in the middle of FETCH.
        @(posedge clk); #1;
        a_if.Opcode = 6'd0; a_if.run = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("midfetch_state", 32'(a_if.dbg_state), 32'(ST_FETCH));
        reset = 1'b1;
        a_if.run = 1'b0;
        #1;
        check_reset_vals("async_rst_fetch");
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;

        // 17 NOPs on a 4-bit counter: wraps to 1.
        burst(17, 1'b1, 1'b1, 1'b0);
        chk("retired_wrap", 32'(a_if.retired), 32'd1);
        chk("no_illegal_after_nops", 32'(a_if.illegal), 32'd0);

        repeat (2) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
